bcd_counter_scan7seg: RTL

- Parametrised successor to the single-digit 161 counter plus 4511 decoder pair.
- DIGITS cascaded BCD decades with a functional parallel load, count enable, up/down counting and a terminal-count output.
- Digits are shown on a time-multiplexed common 7-segment bus with one-hot digit selects, lamp test, blanking and leading-zero suppression.
- Sits between board pushbutton/clock inputs and the display pads at the top level of the counter/display exercises.

---
 rtl/bcd7seg_pkg.sv | 42 ++++
 rtl/bcd_counter_scan7seg_decade.sv | 31 +++
 rtl/bcd_counter_scan7seg.sv | 95 +++++++++
 3 files changed

// File: rtl/bcd7seg_pkg.sv
// Shared segment encodings, BCD decode and scan-divider sizing for the
// multi-decade BCD counter with a multiplexed 7-segment display.
package bcd7seg_pkg;

  localparam logic [7:0] SEG_0   = 8'h3F;
  localparam logic [7:0] SEG_1   = 8'h06;
  localparam logic [7:0] SEG_2   = 8'h5B;
  localparam logic [7:0] SEG_3   = 8'h4F;
  localparam logic [7:0] SEG_4   = 8'h66;
  localparam logic [7:0] SEG_5   = 8'h6D;
  localparam logic [7:0] SEG_6   = 8'h7D;
  localparam logic [7:0] SEG_7   = 8'h07;
  localparam logic [7:0] SEG_8   = 8'h7F;
  localparam logic [7:0] SEG_9   = 8'h6F;
  localparam logic [7:0] SEG_ALL = 8'hFF;
  localparam logic [7:0] SEG_OFF = 8'h00;

  localparam int unsigned SCAN_DIV_DEFAULT = 1000;
  localparam int unsigned SCAN_DIV_W       = $clog2(SCAN_DIV_DEFAULT);

  // A divide-by-1 still needs a 1-bit register to hold the constant 0.
  function automatic int unsigned div_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bcd_counter_scan7seg_decade.sv
// One BCD decade: synchronous load (invalid values load as 0), up/down count
// gated by enable and the chained carry/borrow from lower decades.
module bcd_decade
  import bcd7seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       up,
  input  logic       chain_in,
  output logic       chain_out,
  output logic [3:0] digit
);

  // chain_out is cumulative: all decades up to and including this one are terminal.
  assign chain_out = chain_in & (up ? (digit == 4'd9) : (digit == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (load) begin
      digit <= (load_val > 4'd9) ? 4'd0 : load_val;
    end else if (en && chain_in) begin
      if (up) digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      else    digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_scan7seg.sv
// DIGITS-decade BCD up/down counter with parallel load and terminal count,
// shown on a time-multiplexed 7-segment bus with lamp test and blanking.
module bcd_counter_scan7seg
  import bcd7seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  CP,
  input  logic                  MRN,
  input  logic [4*DIGITS-1:0]   Dn,
  input  logic                  PE_N,
  input  logic                  CEP,
  input  logic                  CET,
  input  logic                  UP,
  input  logic                  LT_N,
  input  logic                  BI_N,
  input  logic                  LZB,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  TC,
  output logic [7:0]            Seg,
  output logic [DIGITS-1:0]     Dig
);

  localparam int unsigned DIV_W = div_width(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS:0]   chain;
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] zero_from;
  logic [DIV_W-1:0]  div;
  logic [IDX_W-1:0]  scan_idx;
  logic [3:0]        cur_digit;
  logic [7:0]        seg_nxt;
  logic [DIGITS-1:0] dig_nxt;
  logic              blanked;

  assign chain[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_decade
    bcd_decade u_decade (
      .clk       (CP),
      .rst_n     (MRN),
      .load      (!PE_N),
      .load_val  (Dn[4*k +: 4]),
      .en        (CEP & CET),
      .up        (UP),
      .chain_in  (chain[k]),
      .chain_out (chain[k+1]),
      .digit     (Q[4*k +: 4])
    );
    assign digit_zero[k] = (Q[4*k +: 4] == 4'd0);
  end

  assign TC = CET & chain[DIGITS];

  // zero_from[k]: decades k..DIGITS-1 are all zero.
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = digit_zero[DIGITS-1];
    for (int unsigned i = 1; i < DIGITS; i++) begin
      zero_from[DIGITS-1-i] = digit_zero[DIGITS-1-i] & zero_from[DIGITS-i];
    end
  end

  always_comb begin
    cur_digit = Q[4*scan_idx +: 4];
    blanked   = LZB && (scan_idx != '0) && zero_from[scan_idx];
    dig_nxt   = '0;
    dig_nxt[scan_idx] = 1'b1;
    if (!LT_N)        seg_nxt = SEG_ALL;
    else if (!BI_N)   seg_nxt = SEG_OFF;
    else if (blanked) seg_nxt = SEG_OFF;
    else              seg_nxt = bcd_to_seg(cur_digit);
  end

  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) begin
      div      <= '0;
      scan_idx <= '0;
      Seg      <= '0;
      Dig      <= '0;
    end else begin
      Seg <= seg_nxt;
      Dig <= dig_nxt;
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div      <= '0;
        scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule
